// File: rtl/rgb_hue_pkg.sv
// ============================================================================
// rgb_hue_pkg : segment encoding and step-mode colours for rgb_hue_pwm
// Rev 1.0
// ============================================================================
`default_nettype none

package rgb_hue_pkg;

  typedef enum logic [2:0] {
    SEG_RED     = 3'd0,
    SEG_YELLOW  = 3'd1,
    SEG_GREEN   = 3'd2,
    SEG_CYAN    = 3'd3,
    SEG_BLUE    = 3'd4,
    SEG_MAGENTA = 3'd5
  } seg_e;

  localparam int c_seg_count = 6;

  // Step-mode colours as {R,G,B} on/off flags
  localparam logic [2:0] c_rgb_red     = 3'b100;
  localparam logic [2:0] c_rgb_yellow  = 3'b110;
  localparam logic [2:0] c_rgb_green   = 3'b010;
  localparam logic [2:0] c_rgb_cyan    = 3'b011;
  localparam logic [2:0] c_rgb_blue    = 3'b001;
  localparam logic [2:0] c_rgb_magenta = 3'b101;

  function automatic seg_e next_seg(input seg_e s);
    if (s == seg_e'(c_seg_count - 1)) begin
      return SEG_RED;
    end
    return seg_e'(s + 3'd1);
  endfunction

  function automatic logic [2:0] seg_colour(input seg_e s);
    logic [2:0] rgb;
    rgb = 3'b000;
    case (s)
      SEG_RED:     rgb = c_rgb_red;
      SEG_YELLOW:  rgb = c_rgb_yellow;
      SEG_GREEN:   rgb = c_rgb_green;
      SEG_CYAN:    rgb = c_rgb_cyan;
      SEG_BLUE:    rgb = c_rgb_blue;
      SEG_MAGENTA: rgb = c_rgb_magenta;
      default:     rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
// pwm_channel : frame-synchronous duty shadow, optional gamma, registered compare
// Optional feature macro: RGB_HUE_GAMMA_EN. Rev 1.0
// ============================================================================
`default_nettype none

module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic [PWM_BITS-1:0] i_cnt,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] w_duty;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_pwm;

`ifdef RGB_HUE_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_sq;
  assign w_sq   = i_duty * i_duty;
  assign w_duty = PWM_BITS'(w_sq >> PWM_BITS);
`else
  assign w_duty = i_duty;
`endif

  // Shadow only updates at the frame boundary so a frame never changes mid-way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
    end else if (i_load) begin
      r_duty <= w_duty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (i_cnt < r_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/rgb_hue_pwm.sv
// ============================================================================
// rgb_hue_pwm : RGB LED hue fader (linear fade or six-colour step) with PWM drive
// Optional feature macro: RGB_HUE_GAMMA_EN (squared duty curve). Rev 1.0
// ============================================================================
`default_nettype none

module rgb_hue_pwm
  import rgb_hue_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] seg
);

  localparam int                   c_step_w    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [c_step_w-1:0]  c_step_last = c_step_w'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0]  c_max       = '1;

  logic [c_step_w-1:0] r_step_cnt;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_level;
  seg_e                r_seg;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_frame;
  logic [PWM_BITS-1:0] w_duty_r;
  logic [PWM_BITS-1:0] w_duty_g;
  logic [PWM_BITS-1:0] w_duty_b;
  logic [2:0]          w_step_rgb;

  // Tick is registered so one raised on the last enabled cycle is still applied after en drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (en) begin
        if (r_step_cnt == c_step_last) begin
          r_step_cnt <= '0;
          r_tick     <= 1'b1;
        end else begin
          r_step_cnt <= r_step_cnt + c_step_w'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_seg   <= SEG_RED;
    end else if (r_tick) begin
      if (r_level == c_max) begin
        r_level <= '0;
        r_seg   <= next_seg(r_seg);
      end else begin
        r_level <= r_level + PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  assign w_frame    = (r_pwm_cnt == c_max);
  assign w_step_rgb = seg_colour(r_seg);

  always_comb begin
    w_duty_r = '0;
    w_duty_g = '0;
    w_duty_b = '0;
    if (mode) begin
      w_duty_r = {PWM_BITS{w_step_rgb[2]}};
      w_duty_g = {PWM_BITS{w_step_rgb[1]}};
      w_duty_b = {PWM_BITS{w_step_rgb[0]}};
    end else begin
      case (r_seg)
        SEG_RED: begin
          w_duty_r = c_max;
          w_duty_g = r_level;
        end
        SEG_YELLOW: begin
          w_duty_r = c_max - r_level;
          w_duty_g = c_max;
        end
        SEG_GREEN: begin
          w_duty_g = c_max;
          w_duty_b = r_level;
        end
        SEG_CYAN: begin
          w_duty_g = c_max - r_level;
          w_duty_b = c_max;
        end
        SEG_BLUE: begin
          w_duty_r = r_level;
          w_duty_b = c_max;
        end
        SEG_MAGENTA: begin
          w_duty_r = c_max;
          w_duty_b = c_max - r_level;
        end
        default: begin
          w_duty_r = '0;
          w_duty_g = '0;
          w_duty_b = '0;
        end
      endcase
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_frame),
    .i_duty (w_duty_r),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (RGB_R)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_frame),
    .i_duty (w_duty_g),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (RGB_G)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_frame),
    .i_duty (w_duty_b),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (RGB_B)
  );

  assign seg = r_seg;

endmodule

`default_nettype wire

// File: doc/rgb_hue_pwm.md
RGB_HUE_PWM -- requirements
Module: rgb_hue_pwm

Interface
REQ-001 Parameter PWM_BITS, default 8, SHALL set the PWM counter and duty width; MAX = 2**PWM_BITS-1.
REQ-002 Parameter STEP_CYCLES, default 12000, SHALL set the clk cycles per fade step (1 ms at 12 MHz).
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port en, input, 1: 1 = hue advances; 0 = hue frozen while PWM keeps running.
REQ-006 Port mode, input, 1: 0 = linear fade; 1 = hard six-colour step.
REQ-007 Ports RGB_R, RGB_G, RGB_B, output, 1 each: registered PWM drive, active-high.
REQ-008 Port seg, output, 3: current hue segment, 0..5.

Function
REQ-009 The step counter SHALL count 0..STEP_CYCLES-1 while en=1, hold while en=0, and emit a one-cycle tick on wrap.
REQ-010 Each tick SHALL increment level (PWM_BITS wide); a tick at level==MAX SHALL set level=0 and advance seg, with 5 wrapping to 0.
REQ-011 Fade duties SHALL be: seg0 R=MAX,G=level,B=0; seg1 R=MAX-level,G=MAX,B=0; seg2 R=0,G=MAX,B=level; seg3 R=0,G=MAX-level,B=MAX; seg4 R=level,G=0,B=MAX; seg5 R=MAX,G=0,B=MAX-level.
REQ-012 Step mode SHALL ignore level and use, per seg 0..5: red, yellow, green, cyan, blue, magenta, each on channel at MAX and each off channel at 0.
REQ-013 The PWM counter SHALL be free-running, PWM_BITS wide, and wrap MAX->0.
REQ-014 Each channel SHALL load its target duty into a shadow register only in the cycle where the PWM counter equals MAX (frame boundary), so no mid-frame glitches occur.
REQ-015 Output SHALL be registered (pwm_cnt < shadow duty): one cycle of latency; duty 0 -> never high; duty MAX -> high MAX of 2**PWM_BITS cycles.
REQ-016 A mode or seg change SHALL affect outputs only from the next frame boundary.
REQ-017 If en falls in the same cycle as a tick, the tick SHALL still be applied, and the counter SHALL then hold.

Reset
REQ-018 On rst_n=0, step counter, level, seg, PWM counter and shadow duties SHALL clear to 0, and RGB_R/G/B SHALL be 0, immediately and asynchronously.
REQ-019 Reset asserted mid-frame or mid-segment SHALL abandon all progress; after release, operation restarts at seg 0, level 0.

Configuration
REQ-020 Macro RGB_HUE_GAMMA_EN, when defined, SHALL replace each target duty d with (d*d)>>PWM_BITS before the shadow load; undefined, the duty SHALL pass linearly.
REQ-021 With RGB_HUE_GAMMA_EN, duty MAX SHALL map to MAX-1 and duty 0 to 0; the squaring multiplier SHALL be 2*PWM_BITS wide.

Structure
REQ-022 Package rgb_hue_pkg SHALL hold the segment enum typedef (SEG_RED..SEG_MAGENTA), the segment count of 6, and the step-mode colour constants.
REQ-023 A sub-module pwm_channel (shadow register, optional gamma, compare, output flop) SHALL be instantiated three times, sharing one PWM counter.

Verification
REQ-024 The bench SHALL use PWM_BITS=4, STEP_CYCLES=3 and cover these directed scenarios:
- Reset release, en=1, mode=0 -> RGB_R high 15 of every 16 cycles; G duty rises 0,1,..15 per tick; seg=1 after 16 ticks (48 cycles).
- Run 96 ticks -> seg sequence 0..5 then back to 0; R/G/B duties match REQ-011 at each seg boundary.
- mode=1, seg=3 -> R always 0; G and B high 15/16; a mode toggle mid-frame changes outputs only after pwm_cnt==15.
- en=0 for 100 cycles at level 7 -> level and seg unchanged, and PWM waveform still toggling; en=1 -> resumes at level 8 after 3 cycles.
- rst_n pulsed low mid-segment (seg 4, level 9) -> outputs 0 in the same cycle; after release, seg=0, level=0.
- With RGB_HUE_GAMMA_EN, level 8 -> G duty 4 (4 of 16 high); level 15 -> duty 14.
